// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared sizes, FSM states and border test for the ridge extractor
package dt_pkg;

  localparam int IMG_LOG2 = 7;
  localparam int PIX_W    = 8;
  localparam int WORD_W   = 16;
  localparam int IDX_W    = 2 * IMG_LOG2;
  localparam int SKL_W    = IDX_W - 4;
  localparam int SIDE     = 1 << IMG_LOG2;

  typedef enum logic [3:0] {
    IDLE, PIX, CEN, RN, RW, RE, RS, WR, DONE
  } state_e;

  // Border pixels have an incomplete 4-neighbourhood, so they are never read.
  function automatic logic is_border(input logic [IDX_W-1:0] idx);
    logic [IMG_LOG2-1:0] row;
    logic [IMG_LOG2-1:0] col;
    row = idx[IDX_W-1:IMG_LOG2];
    col = idx[IMG_LOG2-1:0];
    return (row == '0) || (row == '1) || (col == '0) || (col == '1);
  endfunction

endpackage

// File: rtl/dt_bit_packer.sv
// rtl/dt_bit_packer.sv - MSB-first 16-bit skeleton word packer with word-complete flag
module dt_bit_packer
  import dt_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic [WORD_W-1:0] word_o,
  output logic              last_o
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = {sr_q[WORD_W-2:0], bit_i};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o = sr_q;
  // High while the next shifted bit completes the word.
  assign last_o = (cnt_q == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/dt_ridge_extract.sv
// rtl/dt_ridge_extract.sv - scans the distance map and writes a 1-bpp ridge skeleton
module dt_ridge_extract
  import dt_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              res_rd_o,
  output logic [IDX_W-1:0]  res_addr_o,
  input  logic [PIX_W-1:0]  res_di_i,
  output logic              skl_wr_o,
  output logic [SKL_W-1:0]  skl_addr_o,
  output logic [WORD_W-1:0] skl_do_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [PIX_W-1:0]  max_dist_o,
  output logic [IDX_W-1:0]  ridge_cnt_o
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PIX_W-1:0]  v_q, v_d;
  logic              fail_q, fail_d;
  logic [PIX_W-1:0]  max_q, max_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              adv, adv_bit, neigh_gt;
  logic              pk_clear, pk_shift, pk_bit, pk_last;
  logic [WORD_W-1:0] pk_word;

  dt_bit_packer u_packer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (pk_clear),
    .shift_i (pk_shift),
    .bit_i   (pk_bit),
    .word_o  (pk_word),
    .last_o  (pk_last)
  );

  assign neigh_gt = (res_di_i > v_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    v_d        = v_q;
    fail_d     = fail_q;
    max_d      = max_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    res_rd_o   = 1'b0;
    res_addr_o = '0;
    skl_wr_o   = 1'b0;
    skl_addr_o = '0;
    skl_do_o   = '0;
    pk_clear   = 1'b0;
    pk_shift   = 1'b0;
    pk_bit     = 1'b0;
    adv        = 1'b0;
    adv_bit    = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        done_d   = 1'b0;
        max_d    = '0;
        cnt_d    = '0;
        idx_d    = '0;
        pk_clear = 1'b1;
        state_d  = PIX;
      end
      PIX: if (is_border(idx_q)) begin
        adv = 1'b1;
      end else begin
        res_rd_o   = 1'b1;
        res_addr_o = idx_q;
        state_d    = CEN;
      end
      CEN: begin
        v_d    = res_di_i;
        fail_d = 1'b0;
        if (res_di_i > max_q) max_d = res_di_i;
        if (res_di_i == '0) begin
          adv = 1'b1;
        end else begin
          res_rd_o   = 1'b1;
          res_addr_o = idx_q - IDX_W'(SIDE);
          state_d    = RN;
        end
      end
      // Each neighbour state checks the word requested last cycle and requests the next.
      RN: begin
        fail_d     = fail_q | neigh_gt;
        res_rd_o   = 1'b1;
        res_addr_o = idx_q - IDX_W'(1);
        state_d    = RW;
      end
      RW: begin
        fail_d     = fail_q | neigh_gt;
        res_rd_o   = 1'b1;
        res_addr_o = idx_q + IDX_W'(1);
        state_d    = RE;
      end
      RE: begin
        fail_d     = fail_q | neigh_gt;
        res_rd_o   = 1'b1;
        res_addr_o = idx_q + IDX_W'(SIDE);
        state_d    = RS;
      end
      RS: begin
        adv     = 1'b1;
        adv_bit = !(fail_q | neigh_gt);
        cnt_d   = cnt_q + IDX_W'(adv_bit);
      end
      WR: begin
        skl_wr_o   = 1'b1;
        skl_addr_o = idx_q[IDX_W-1:4];
        skl_do_o   = pk_word;
        if (idx_q == '1) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = PIX;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (adv) begin
      pk_shift = 1'b1;
      pk_bit   = adv_bit;
      if (pk_last) begin
        state_d = WR;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = PIX;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      v_q     <= '0;
      fail_q  <= 1'b0;
      max_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      v_q     <= v_d;
      fail_q  <= fail_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o      = (state_q != IDLE) && (state_q != DONE);
  assign done_o      = done_q;
  assign max_dist_o  = max_q;
  assign ridge_cnt_o = cnt_q;

endmodule
